// File: rtl/mshr_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mshr_line_buffer
// Description : Refill line buffer for the MSHR file. One line per MSHR with
//               per-beat valid mask, line-full flags, per-entry beat counts,
//               per-entry clear and a registered read response.
// Option      : MSHR_LB_BYPASS_EN forwards a same-cycle matching write to a read.
// Revision    : 1.0 - initial release
// ============================================================================
module mshr_line_buffer #(
    parameter int N_MSHRS   = 4,
    parameter int BEATS     = 4,
    parameter int DATA_BITS = 64,
    parameter int ID_W      = (N_MSHRS > 1) ? $clog2(N_MSHRS) : 1,
    parameter int OFF_W     = $clog2(BEATS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_valid,
    input  logic [ID_W-1:0]              wr_id,
    input  logic [OFF_W-1:0]             wr_offset,
    input  logic [DATA_BITS-1:0]         wr_data,
    input  logic                         rd_valid,
    input  logic [ID_W-1:0]              rd_id,
    input  logic [OFF_W-1:0]             rd_offset,
    output logic                         rd_resp_valid,
    output logic [DATA_BITS-1:0]         rd_resp_data,
    output logic                         rd_resp_hit,
    input  logic                         clr_valid,
    input  logic [ID_W-1:0]              clr_id,
    output logic [N_MSHRS-1:0]           line_full,
    output logic [N_MSHRS*(OFF_W+1)-1:0] beat_count
);

    localparam int C_CNT_W = OFF_W + 1;

    logic [DATA_BITS-1:0] r_data [N_MSHRS][BEATS];
    logic [BEATS-1:0]     r_mask [N_MSHRS];
    logic [BEATS-1:0]     w_mask_nxt [N_MSHRS];

    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic [DATA_BITS-1:0] w_rd_data;
    logic                 w_rd_hit;

    function automatic logic [C_CNT_W-1:0] popcount(input logic [BEATS-1:0] m);
        logic [C_CNT_W-1:0] cnt;
        cnt = '0;
        for (int b = 0; b < BEATS; b++) begin
            cnt = cnt + C_CNT_W'(m[b]);
        end
        return cnt;
    endfunction

    assign w_wr_in_range = (int'(wr_id) < N_MSHRS);
    assign w_rd_in_range = (int'(rd_id) < N_MSHRS);

    // Clear is applied before a same-cycle write to the same entry.
    always_comb begin
        for (int i = 0; i < N_MSHRS; i++) begin
            w_mask_nxt[i] = r_mask[i];
            if (clr_valid && (clr_id == ID_W'(i))) begin
                w_mask_nxt[i] = '0;
            end
            if (wr_valid && (wr_id == ID_W'(i))) begin
                w_mask_nxt[i][wr_offset] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            line_full  <= '0;
            beat_count <= '0;
            for (int i = 0; i < N_MSHRS; i++) begin
                r_mask[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_MSHRS; i++) begin
                r_mask[i]                        <= w_mask_nxt[i];
                line_full[i]                     <= &w_mask_nxt[i];
                beat_count[i*C_CNT_W +: C_CNT_W] <= popcount(w_mask_nxt[i]);
            end
        end
    end

    // Data storage has no reset; reset only suppresses the write.
    always_ff @(posedge clock) begin
        if (!reset && wr_valid && w_wr_in_range) begin
            r_data[wr_id][wr_offset] <= wr_data;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_hit  = 1'b0;
        if (w_rd_in_range) begin
            w_rd_data = r_data[rd_id][rd_offset];
            w_rd_hit  = r_mask[rd_id][rd_offset];
        end
`ifdef MSHR_LB_BYPASS_EN
        if (w_rd_in_range && wr_valid && (wr_id == rd_id) && (wr_offset == rd_offset)) begin
            w_rd_data = wr_data;
            w_rd_hit  = 1'b1;
        end
`else
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_resp_valid <= 1'b0;
            rd_resp_hit   <= 1'b0;
            rd_resp_data  <= '0;
        end else begin
            rd_resp_valid <= rd_valid;
            if (rd_valid) begin
                rd_resp_data <= w_rd_data;
                rd_resp_hit  <= w_rd_hit;
            end else begin
                rd_resp_hit  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mshr_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mshr_line_buffer
// Description : Directed self-checking bench for mshr_line_buffer (default size).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mshr_line_buffer;

    localparam int N  = 4;
    localparam int B  = 4;
    localparam int DW = 64;
    localparam int IW = 2;
    localparam int OW = 2;
    localparam int CW = OW + 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            wr_valid;
    logic [IW-1:0]   wr_id;
    logic [OW-1:0]   wr_offset;
    logic [DW-1:0]   wr_data;
    logic            rd_valid;
    logic [IW-1:0]   rd_id;
    logic [OW-1:0]   rd_offset;
    logic            rd_resp_valid;
    logic [DW-1:0]   rd_resp_data;
    logic            rd_resp_hit;
    logic            clr_valid;
    logic [IW-1:0]   clr_id;
    logic [N-1:0]    line_full;
    logic [N*CW-1:0] beat_count;

    int total = 0;
    int bad   = 0;

    mshr_line_buffer #(.N_MSHRS(N), .BEATS(B), .DATA_BITS(DW)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_id(wr_id), .wr_offset(wr_offset), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_offset(rd_offset),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_hit(rd_resp_hit),
        .clr_valid(clr_valid), .clr_id(clr_id),
        .line_full(line_full), .beat_count(beat_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt(input int i);
        return beat_count[i*CW +: CW];
    endfunction

    task automatic idle();
        wr_valid = 1'b0; rd_valid = 1'b0; clr_valid = 1'b0;
    endtask

    task automatic wr(input int id, input int off, input logic [DW-1:0] d);
        wr_valid = 1'b1; wr_id = IW'(id); wr_offset = OW'(off); wr_data = d;
    endtask

    task automatic rd(input int id, input int off);
        rd_valid = 1'b1; rd_id = IW'(id); rd_offset = OW'(off);
    endtask

    task automatic clr(input int id);
        clr_valid = 1'b1; clr_id = IW'(id);
    endtask

    initial begin
        reset = 1'b1; idle();
        wr_id = '0; wr_offset = '0; wr_data = '0;
        rd_id = '0; rd_offset = '0; clr_id = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_valid", 64'(rd_resp_valid), 64'd0);
        chk("rst_hit",   64'(rd_resp_hit),   64'd0);
        chk("rst_data",  rd_resp_data,       64'd0);
        chk("rst_full",  64'(line_full),     64'd0);
        chk("rst_count", 64'(beat_count),    64'd0);

        // Read of an empty entry
        rd(0, 0); step(); idle();
        chk("empty_rd_valid", 64'(rd_resp_valid), 64'd1);
        chk("empty_rd_hit",   64'(rd_resp_hit),   64'd0);
        chk("empty_full",     64'(line_full),     64'd0);
        chk("empty_count",    64'(beat_count),    64'd0);

        // Fill id2
        for (int k = 0; k < 4; k++) begin
            wr(2, k, 64'hA0 + 64'(k)); step();
            chk("fill2_count", 64'(cnt(2)), 64'(k + 1));
        end
        idle();
        chk("fill2_full", 64'(line_full), 64'b0100);
        rd(2, 3); step(); idle();
        chk("rd23_valid", 64'(rd_resp_valid), 64'd1);
        chk("rd23_data",  rd_resp_data,       64'hA3);
        chk("rd23_hit",   64'(rd_resp_hit),   64'd1);
        step();
        chk("idle_valid", 64'(rd_resp_valid), 64'd0);
        chk("idle_hit",   64'(rd_resp_hit),   64'd0);
        chk("idle_hold",  rd_resp_data,       64'hA3);

        // Rewrite same beat
        wr(1, 2, 64'h55); step();
        wr(1, 2, 64'h56); step(); idle();
        chk("rewrite_count", 64'(cnt(1)), 64'd1);
        rd(1, 2); step(); idle();
        chk("rewrite_data", rd_resp_data,     64'h56);
        chk("rewrite_hit",  64'(rd_resp_hit), 64'd1);

        // Fill id3, then clear + write same id
        for (int k = 0; k < 4; k++) begin
            wr(3, k, 64'h30 + 64'(k)); step();
        end
        idle();
        chk("fill3_full",  64'(line_full), 64'b1100);
        chk("fill3_count", 64'(cnt(3)),    64'd4);
        clr(3); wr(3, 1, 64'h77); step(); idle();
        chk("clrwr_count", 64'(cnt(3)),    64'd1);
        chk("clrwr_full",  64'(line_full), 64'b0100);
        rd(3, 1); step(); idle();
        chk("clrwr_rd1_data", rd_resp_data,     64'h77);
        chk("clrwr_rd1_hit",  64'(rd_resp_hit), 64'd1);
        rd(3, 0); step(); idle();
        chk("clrwr_rd0_hit",  64'(rd_resp_hit), 64'd0);
        chk("clrwr_rd0_data", rd_resp_data,     64'h30);

        // Clear and write on different ids
        clr(2); wr(1, 0, 64'h10); step(); idle();
        chk("indep_count2", 64'(cnt(2)),    64'd0);
        chk("indep_count1", 64'(cnt(1)),    64'd2);
        chk("indep_full",   64'(line_full), 64'd0);

        // Read and clear same id returns pre-clear state
        rd(1, 2); clr(1); step(); idle();
        chk("rdclr_data",   rd_resp_data,     64'h56);
        chk("rdclr_hit",    64'(rd_resp_hit), 64'd1);
        chk("rdclr_count1", 64'(cnt(1)),      64'd0);

        // Same-cycle write and read
        wr(0, 0, 64'hBEEF); step();
        wr(0, 0, 64'hDEAD); rd(0, 0); step(); idle();
`ifdef MSHR_LB_BYPASS_EN
        chk("rdwr_data", rd_resp_data, 64'hDEAD);
`else
        chk("rdwr_data", rd_resp_data, 64'hBEEF);
`endif
        chk("rdwr_hit", 64'(rd_resp_hit), 64'd1);
        rd(0, 0); step(); idle();
        chk("rdwr_after", rd_resp_data, 64'hDEAD);

        // Reset mid-fill overrides a concurrent write and read
        clr(0); step(); idle();
        wr(0, 0, 64'h1); step();
        wr(0, 1, 64'h2); step(); idle();
        chk("mid_count_pre", 64'(cnt(0)), 64'd2);
        reset = 1'b1; wr(0, 2, 64'h3); rd(0, 0); step();
        reset = 1'b0; idle();
        chk("mid_count", 64'(cnt(0)),        64'd0);
        chk("mid_full",  64'(line_full),     64'd0);
        chk("mid_valid", 64'(rd_resp_valid), 64'd0);
        chk("mid_hit",   64'(rd_resp_hit),   64'd0);
        rd(0, 2); step(); idle();
        chk("mid_rd_hit", 64'(rd_resp_hit), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mshr_line_buffer.md
Name: mshr_line_buffer

Overview:
- Parametrised refill line buffer for the non-blocking data cache MSHR file.
- Holds one cache line per MSHR and accepts refill beats from the TileLink grant path, addressed by MSHR id and beat offset.
- The MSHR replays its line to the data array by reading the buffer one beat at a time.
- Generalises the fixed 2-bit id / 2-bit offset write and read requests to N MSHRs × B beats, and adds per-beat valid tracking, line-complete flags, per-entry clear and a registered read response.

Parameters:
- N_MSHRS, 4, number of entries, one line per MSHR; must be ≥1.
- BEATS, 4, beats per cache line; power of two, ≥2.
- DATA_BITS, 64, beat width in bits.
- ID_W, $clog2(N_MSHRS) floored at 1, derived; id field width.
- OFF_W, $clog2(BEATS), derived; offset field width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- wr_valid  in  1  write request valid.
- wr_id  in  ID_W  target MSHR entry.
- wr_offset  in  OFF_W  beat index within line.
- wr_data  in  DATA_BITS  beat data.
- rd_valid  in  1  read request valid.
- rd_id  in  ID_W  entry to read.
- rd_offset  in  OFF_W  beat to read.
- rd_resp_valid  out  1  read response valid, one cycle after rd_valid.
- rd_resp_data  out  DATA_BITS  read data.
- rd_resp_hit  out  1  the beat was valid at read time.
- clr_valid  in  1  free entry; pulse when the MSHR retires.
- clr_id  in  ID_W  entry to clear.
- line_full  out  N_MSHRS  bit i = all BEATS beats of entry i valid.
- beat_count  out  N_MSHRS*(OFF_W+1)  per-entry count of valid beats; entry i occupies bits [i*(OFF_W+1) +: OFF_W+1].

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Storage: N_MSHRS×BEATS×DATA_BITS register array plus a BEATS-bit valid mask per entry.
- Reset:
  - all masks = 0; line_full = 0; beat_count = 0.
  - rd_resp_valid = 0; rd_resp_hit = 0; rd_resp_data = 0.
  - The data array is not reset.
- Write path:
  - Always accepted; there is no ready signal.
  - On wr_valid: data[wr_id][wr_offset] ← wr_data and mask bit ← 1 at the next edge.
  - Rewriting an already-valid beat overwrites the data; beat_count does not double-count.
- beat_count[i] = popcount(mask[i]); it is registered and reflects state after the edge.
- line_full[i] = (mask[i] == all ones); registered, same cycle as beat_count.
- Read path, latency 1:
  - rd_resp_valid ← rd_valid.
  - rd_resp_data ← data[rd_id][rd_offset].
  - rd_resp_hit ← mask[rd_id][rd_offset], sampled pre-edge.
  - When rd_valid = 0: rd_resp_data holds its last value; rd_resp_hit ← 0.
- Clear:
  - On clr_valid: mask[clr_id] ← 0; data is untouched.
  - Next cycle: line_full[clr_id] = 0 and count = 0.
- Simultaneous events, same cycle:
  - Write and clear, same id: clear applies first, then the write, so the resulting mask has only wr_offset set and count = 1.
  - Write and clear, different ids: both apply independently.
  - Read and write, same id/offset: without bypass, the read returns old data and the old hit bit.
  - Read and clear, same id: the read returns pre-clear data and hit.
- Out-of-range ids (id ≥ N_MSHRS when N_MSHRS is not a power of two): the write or clear is ignored; a read returns hit = 0 and data = 0.
- reset asserted mid-operation: overrides every event that cycle; no write, clear or read response takes effect.

Optional Feature:
- Macro: MSHR_LB_BYPASS_EN.
- Defined: a same-cycle write whose id/offset matches a read forwards the data, so rd_resp_data = wr_data and rd_resp_hit = 1 on the next cycle. Combined with a same-id clear, the write-after-clear ordering still yields the forwarded data with hit = 1.
- Undefined: read-before-write semantics as stated in Behaviour; no forwarding mux is present.

Test Plan:
- Reset, then read id0/off0 → rd_resp_valid = 1 next cycle, rd_resp_hit = 0, line_full = 4'b0000, all counts 0.
- Write id2 offsets 0..3 with data 0xA0..0xA3 on consecutive cycles → count[2] steps 1,2,3,4; line_full = 4'b0100 after the 4th edge; reading id2/off3 returns 0xA3 with hit = 1.
- Write id1/off2 = 0x55 twice → count[1] = 1; a read returns the second value.
- Fill id3, then assert clr id3 together with a write id3/off1 = 0x77 → next cycle count[3] = 1, line_full[3] = 0; id3/off1 reads 0x77 hit = 1; id3/off0 reads hit = 0.
- Write and read id0/off0 in the same cycle with data 0xDEAD, prior 0xBEEF valid:
  - without the macro → response 0xBEEF, hit = 1.
  - with MSHR_LB_BYPASS_EN → response 0xDEAD, hit = 1.
- Assert reset mid-fill after 2 beats of id0 with a concurrent write → count[0] = 0, line_full = 0, rd_resp_valid = 0 the next cycle.
